// File: rtl/vscale_alu_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// vscale_alu_arbiter_pkg
// Shared ALU op-code definitions used by vscale_alu and vscale_alu_arbiter,
// plus the round-robin port type and the two-requester grant helper.
// No ports (package).
// ----------------------------------------------------------------------------
package vscale_alu_arbiter_pkg;

   // ALU operation codes (single source for the ALU and the arbiter)
   localparam int unsigned ALU_OP_WIDTH = 4;

   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'd0;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'd1;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'd2;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'd3;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'd4;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'd5;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SEQ  = 4'd8;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SNE  = 4'd9;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'd10;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'd11;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'd12;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SGE  = 4'd13;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'd14;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SGEU = 4'd15;

   // Round-robin pointer values: which port wins a tie
   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_e;

   // One-hot grant {g1, g0} from the two eligibility bits and the tie pointer
   function automatic logic [1:0] rr_grant(input logic elig0,
                                           input logic elig1,
                                           input port_e rr);
      logic g0;
      logic g1;
      g0 = elig0 && (!elig1 || (rr == PORT0));
      g1 = elig1 && (!elig0 || (rr == PORT1));
      return {g1, g0};
   endfunction

endpackage

// File: rtl/vscale_alu.sv
// ----------------------------------------------------------------------------
// vscale_alu
// Combinational integer ALU. Unknown op codes produce zero.
// Ports:
//   op            in  ALU_OP_WIDTH  operation code
//   in1, in2      in  XLEN          operands (shift amount from in2 low bits)
//   out           out XLEN          result
//   sum_diff_out  out XLEN          in1+in2, or in1-in2 for SUB
// ----------------------------------------------------------------------------
module vscale_alu
   import vscale_alu_arbiter_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [ALU_OP_WIDTH-1:0] op,
   input  logic [XLEN-1:0]         in1,
   input  logic [XLEN-1:0]         in2,
   output logic [XLEN-1:0]         out,
   output logic [XLEN-1:0]         sum_diff_out
);

   localparam int unsigned SHAMT_W = $clog2(XLEN);

   logic [SHAMT_W-1:0] w_shamt;

   assign w_shamt      = in2[SHAMT_W-1:0];
   assign sum_diff_out = (op == ALU_OP_SUB) ? (in1 - in2) : (in1 + in2);

   // Result mux
   always_comb begin
      out = '0;
      case (op)
         ALU_OP_ADD  : out = in1 + in2;
         ALU_OP_SLL  : out = in1 << w_shamt;
         ALU_OP_XOR  : out = in1 ^ in2;
         ALU_OP_OR   : out = in1 | in2;
         ALU_OP_AND  : out = in1 & in2;
         ALU_OP_SRL  : out = in1 >> w_shamt;
         ALU_OP_SEQ  : out = XLEN'(in1 == in2);
         ALU_OP_SNE  : out = XLEN'(in1 != in2);
         ALU_OP_SUB  : out = in1 - in2;
         ALU_OP_SRA  : out = XLEN'($signed(in1) >>> w_shamt);
         ALU_OP_SLT  : out = XLEN'($signed(in1) <  $signed(in2));
         ALU_OP_SGE  : out = XLEN'($signed(in1) >= $signed(in2));
         ALU_OP_SLTU : out = XLEN'(in1 <  in2);
         ALU_OP_SGEU : out = XLEN'(in1 >= in2);
         default     : out = '0;
      endcase
   end

endmodule

// File: rtl/vscale_alu_arbiter.sv
// ----------------------------------------------------------------------------
// vscale_alu_arbiter
// Shares one vscale_alu between two requesters with valid/ready handshakes,
// round-robin tie-breaking and a one-entry registered result slot per port.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   reqN_valid / reqN_ready      request handshake (ready = grant, comb.)
//   reqN_op, reqN_in1, reqN_in2  request payload
//   respN_valid / respN_ready    response handshake
//   respN_data                   registered ALU result
// ----------------------------------------------------------------------------
module vscale_alu_arbiter
   import vscale_alu_arbiter_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,

   input  logic                    req0_valid,
   output logic                    req0_ready,
   input  logic [ALU_OP_WIDTH-1:0] req0_op,
   input  logic [XLEN-1:0]         req0_in1,
   input  logic [XLEN-1:0]         req0_in2,

   input  logic                    req1_valid,
   output logic                    req1_ready,
   input  logic [ALU_OP_WIDTH-1:0] req1_op,
   input  logic [XLEN-1:0]         req1_in1,
   input  logic [XLEN-1:0]         req1_in2,

   output logic                    resp0_valid,
   input  logic                    resp0_ready,
   output logic [XLEN-1:0]         resp0_data,

   output logic                    resp1_valid,
   input  logic                    resp1_ready,
   output logic [XLEN-1:0]         resp1_data
);

   port_e                   r_rr;
   logic                    r_resp0_valid;
   logic                    r_resp1_valid;
   logic [XLEN-1:0]         r_resp0_data;
   logic [XLEN-1:0]         r_resp1_data;

   logic                    w_elig0;
   logic                    w_elig1;
   logic [1:0]              w_grant;
   logic                    w_gnt0;
   logic                    w_gnt1;
   logic [ALU_OP_WIDTH-1:0] w_alu_op;
   logic [XLEN-1:0]         w_alu_in1;
   logic [XLEN-1:0]         w_alu_in2;
   logic [XLEN-1:0]         w_alu_out;

   // A port may issue only if its slot is empty or drained this cycle
   assign w_elig0 = req0_valid && (!r_resp0_valid || resp0_ready);
   assign w_elig1 = req1_valid && (!r_resp1_valid || resp1_ready);

   // Grants are forced low while reset is held so no request is accepted
   assign w_grant = rr_grant(w_elig0, w_elig1, r_rr);
   assign w_gnt0  = w_grant[0] && reset_n;
   assign w_gnt1  = w_grant[1] && reset_n;

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;

   // Operand mux: port 0 is the idle default, its result is then discarded
   assign w_alu_op  = w_gnt1 ? req1_op  : req0_op;
   assign w_alu_in1 = w_gnt1 ? req1_in1 : req0_in1;
   assign w_alu_in2 = w_gnt1 ? req1_in2 : req0_in2;

   vscale_alu #(
      .XLEN (XLEN)
   ) u_alu (
      .op           (w_alu_op),
      .in1          (w_alu_in1),
      .in2          (w_alu_in2),
      .out          (w_alu_out),
      .sum_diff_out ()
   );

   // Tie pointer moves to the port that lost (or did not request) this grant
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rr <= PORT0;
      end else if (w_gnt0) begin
         r_rr <= PORT1;
      end else if (w_gnt1) begin
         r_rr <= PORT0;
      end
   end

   // Slot 0: a refill wins over a drain; data holds when merely drained
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_resp0_valid <= 1'b0;
         r_resp0_data  <= '0;
      end else if (w_gnt0) begin
         r_resp0_valid <= 1'b1;
         r_resp0_data  <= w_alu_out;
      end else if (resp0_ready) begin
         r_resp0_valid <= 1'b0;
      end
   end

   // Slot 1: same policy as slot 0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_resp1_valid <= 1'b0;
         r_resp1_data  <= '0;
      end else if (w_gnt1) begin
         r_resp1_valid <= 1'b1;
         r_resp1_data  <= w_alu_out;
      end else if (resp1_ready) begin
         r_resp1_valid <= 1'b0;
      end
   end

   assign resp0_valid = r_resp0_valid;
   assign resp0_data  = r_resp0_data;
   assign resp1_valid = r_resp1_valid;
   assign resp1_data  = r_resp1_data;

endmodule

// File: tb/tb_vscale_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vscale_alu_arbiter
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the arbiter and ALU kept in this bench.
// ----------------------------------------------------------------------------
module tb_vscale_alu_arbiter;

   localparam int unsigned XLEN = 32;

   logic              clk;
   logic              reset_n;
   logic              req0_valid, req1_valid;
   logic              req0_ready, req1_ready;
   logic [3:0]        req0_op, req1_op;
   logic [XLEN-1:0]   req0_in1, req0_in2, req1_in1, req1_in2;
   logic              resp0_valid, resp1_valid;
   logic              resp0_ready, resp1_ready;
   logic [XLEN-1:0]   resp0_data, resp1_data;

   int                errors = 0;
   int                checks = 0;

   // model state: slot contents and which port wins the next tie
   logic              m_valid [2];
   logic [XLEN-1:0]   m_data  [2];
   int                m_prio;

   logic              s_rdy0, s_rdy1;

   vscale_alu_arbiter #(.XLEN(XLEN)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_op     (req0_op),
      .req0_in1    (req0_in1),
      .req0_in2    (req0_in2),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_op     (req1_op),
      .req1_in1    (req1_in1),
      .req1_in2    (req1_in2),
      .resp0_valid (resp0_valid),
      .resp0_ready (resp0_ready),
      .resp0_data  (resp0_data),
      .resp1_valid (resp1_valid),
      .resp1_ready (resp1_ready),
      .resp1_data  (resp1_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference ALU written from the op-code meanings
   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      case (op)
         4'd0:  return a + b;
         4'd1:  return a << sh;
         4'd2:  return a ^ b;
         4'd3:  return a | b;
         4'd4:  return a & b;
         4'd5:  return a >> sh;
         4'd8:  return (a == b) ? 32'd1 : 32'd0;
         4'd9:  return (a != b) ? 32'd1 : 32'd0;
         4'd10: return a - b;
         4'd11: return 32'($signed(a) >>> sh);
         4'd12: return ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
         4'd13: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
         4'd14: return (a <  b) ? 32'd1 : 32'd0;
         4'd15: return (a >= b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_valid[0] = 1'b0; m_valid[1] = 1'b0;
      m_data[0]  = '0;   m_data[1]  = '0;
      m_prio     = 0;
   endtask

   task automatic set0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rr);
      req0_valid = v; req0_op = op; req0_in1 = a; req0_in2 = b; resp0_ready = rr;
   endtask

   task automatic set1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rr);
      req1_valid = v; req1_op = op; req1_in1 = a; req1_in2 = b; resp1_ready = rr;
   endtask

   // One clock: called just after a falling edge with inputs already driven
   task automatic step();
      logic e0, e1;
      int   winner;
      #1;
      s_rdy0 = req0_ready;
      s_rdy1 = req1_ready;
      e0 = req0_valid && (!m_valid[0] || resp0_ready);
      e1 = req1_valid && (!m_valid[1] || resp1_ready);
      if (e0 && e1)  winner = m_prio;
      else if (e0)   winner = 0;
      else if (e1)   winner = 1;
      else           winner = -1;
      check("req0_ready", 32'(s_rdy0), 32'(winner == 0));
      check("req1_ready", 32'(s_rdy1), 32'(winner == 1));
      @(posedge clk);
      if (resp0_ready) m_valid[0] = 1'b0;
      if (resp1_ready) m_valid[1] = 1'b0;
      if (winner == 0) begin
         m_valid[0] = 1'b1;
         m_data[0]  = alu_ref(req0_op, req0_in1, req0_in2);
         m_prio     = 1;
      end else if (winner == 1) begin
         m_valid[1] = 1'b1;
         m_data[1]  = alu_ref(req1_op, req1_in1, req1_in2);
         m_prio     = 0;
      end
      #1;
      check("resp0_valid", 32'(resp0_valid), 32'(m_valid[0]));
      check("resp0_data",  resp0_data, m_data[0]);
      check("resp1_valid", 32'(resp1_valid), 32'(m_valid[1]));
      check("resp1_data",  resp1_data, m_data[1]);
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_operand();
      if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 40));
      return $urandom;
   endfunction

   initial begin
      logic pend0, pend1;

      reset_n = 1'b0;
      set0(1'b0, 4'd0, '0, '0, 1'b0);
      set1(1'b0, 4'd0, '0, '0, 1'b0);
      model_reset();
      @(negedge clk); @(negedge clk);
      check("rst_resp0_valid", 32'(resp0_valid), 32'd0);
      check("rst_resp1_valid", 32'(resp1_valid), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Fill both slots, then reset mid-stream
      set0(1'b1, 4'd0, 32'd1, 32'd2, 1'b0);
      set1(1'b1, 4'd0, 32'd3, 32'd4, 1'b0);
      step();
      step();
      check("full_v0", 32'(resp0_valid), 32'd1);
      check("full_v1", 32'(resp1_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      check("rst_mid_v0", 32'(resp0_valid), 32'd0);
      check("rst_mid_v1", 32'(resp1_valid), 32'd0);
      check("rst_mid_d0", resp0_data, 32'd0);
      check("rst_mid_d1", resp1_data, 32'd0);
      check("rst_mid_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;

      // Contention: grants alternate starting at port 0
      set0(1'b1, 4'd2, 32'hF0, 32'h0F, 1'b1);
      set1(1'b1, 4'd14, 32'd1, 32'd2, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("cont_grant", {30'd0, s_rdy1, s_rdy0}, (i % 2 == 0) ? 32'd1 : 32'd2);
         if (i % 2 == 0) check("cont_xor", resp0_data, 32'hFF);
         else            check("cont_sltu", resp1_data, 32'd1);
      end

      // Single port: ADD then back-to-back SUB
      set1(1'b0, 4'd0, '0, '0, 1'b1);
      set0(1'b1, 4'd0, 32'd5, 32'd7, 1'b1);
      step();
      check("add_ready", 32'(s_rdy0), 32'd1);
      check("add_valid", 32'(resp0_valid), 32'd1);
      check("add_data", resp0_data, 32'd12);
      set0(1'b1, 4'd10, 32'd3, 32'd5, 1'b1);
      step();
      check("sub_data", resp0_data, 32'hFFFF_FFFE);

      // Back-pressure on port 1
      set0(1'b0, 4'd0, '0, '0, 1'b1);
      set1(1'b1, 4'd0, 32'd100, 32'd1, 1'b0);
      step();
      check("bp_fill", resp1_data, 32'd101);
      set1(1'b1, 4'd10, 32'd50, 32'd8, 1'b0);
      for (int i = 0; i < 3; i++) begin
         set0(1'b1, 4'd0, 32'(i), 32'd1, 1'b1);
         step();
         check("bp_rdy1", 32'(s_rdy1), 32'd0);
         check("bp_rdy0", 32'(s_rdy0), 32'd1);
         check("bp_hold1", resp1_data, 32'd101);
      end
      resp1_ready = 1'b1;
      step();
      check("bp_release_rdy1", 32'(s_rdy1), 32'd1);
      check("bp_refill_v1", 32'(resp1_valid), 32'd1);
      check("bp_refill_d1", resp1_data, 32'd42);

      // Drain without refill
      set1(1'b0, 4'd0, '0, '0, 1'b1);
      set0(1'b1, 4'd0, 32'd9, 32'd1, 1'b0);
      step();
      set0(1'b0, 4'd0, '0, '0, 1'b1);
      step();
      check("drain_v0", 32'(resp0_valid), 32'd0);
      check("drain_d0", resp0_data, 32'd10);

      // Op coverage on port 1
      set1(1'b1, 4'd11, 32'h8000_0000, 32'd4, 1'b1);
      step();
      check("op_sra", resp1_data, 32'hF800_0000);
      set1(1'b1, 4'd12, 32'hFFFF_FFFF, 32'd0, 1'b1);
      step();
      check("op_slt", resp1_data, 32'd1);
      set1(1'b1, 4'd6, 32'h1234, 32'h5678, 1'b1);
      step();
      check("op_undef", resp1_data, 32'd0);

      // Randomized traffic; held requests keep a stable payload
      set0(1'b0, 4'd0, '0, '0, 1'b1);
      set1(1'b0, 4'd0, '0, '0, 1'b1);
      step();
      pend0 = 1'b0;
      pend1 = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (!pend0) set0($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), rand_operand(), rand_operand(), 1'b0);
         if (!pend1) set1($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), rand_operand(), rand_operand(), 1'b0);
         resp0_ready = ($urandom_range(0, 2) != 0);
         resp1_ready = ($urandom_range(0, 2) != 0);
         step();
         pend0 = req0_valid && !s_rdy0;
         pend1 = req1_valid && !s_rdy1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
